// File: rtl/cdu_link_pkg.sv
// rtl/cdu_link_pkg.sv - shared widths, limits, EC FSM states and magnitude helper for the AGC CDU link
package cdu_link_pkg;

    localparam int CNT_W = 15;
    localparam int EC_W  = 8;

    localparam logic [CNT_W-1:0] CNT_MAX = 15'h3FFF;   // +16383
    localparam logic [CNT_W-1:0] CNT_MIN = 15'h4000;   // -16384

    typedef enum logic [1:0] {
        EC_IDLE,
        EC_WAIT,
        EC_PULSE
    } ec_state_t;

    // Magnitude of a signed pulse count; one extra bit so -128 yields 128.
    function automatic logic [EC_W:0] ec_mag(input logic [EC_W-1:0] v);
        logic [EC_W:0] ext;
        ext = {v[EC_W-1], v};
        return v[EC_W-1] ? -ext : ext;
    endfunction

endpackage

// File: rtl/agc_cdu_link_if.sv
// rtl/agc_cdu_link_if.sv - CPU-side and CDU-side signal bundle of one AGC CDU link axis
// Modports:
//   master : drives PCDU/MCDU and the cpu_* / ec_* controls, observes counter and CDU lines
//   slave  : the link block itself
interface agc_cdu_link_if;
    import cdu_link_pkg::*;

    logic             PCDU;
    logic             MCDU;
    logic             cpu_zero;
    logic             cpu_ca;
    logic             cpu_eec;
    logic             ec_wr;
    logic [EC_W-1:0]  ec_val;
    logic [CNT_W-1:0] cnt_q;
    logic             AGCZ;
    logic             AGCCA;
    logic             AGCEEC;
    logic             ECP;
    logic             ECM;
    logic             ec_busy;
    logic             cnt_ovf;

    modport master (
        output PCDU, MCDU, cpu_zero, cpu_ca, cpu_eec, ec_wr, ec_val,
        input  cnt_q, AGCZ, AGCCA, AGCEEC, ECP, ECM, ec_busy, cnt_ovf
    );

    modport slave (
        input  PCDU, MCDU, cpu_zero, cpu_ca, cpu_eec, ec_wr, ec_val,
        output cnt_q, AGCZ, AGCCA, AGCEEC, ECP, ECM, ec_busy, cnt_ovf
    );

endinterface

// File: rtl/cdu_pulse_sync.sv
// rtl/cdu_pulse_sync.sv - two-flop synchroniser with rising-edge detect for an asynchronous CDU pulse
// Ports:
//   CLOCKH in  system clock
//   rst    in  synchronous active-high reset
//   din    in  asynchronous level pulse
//   rise   out one-cycle strobe, high the cycle after the synchronised level rises
module cdu_pulse_sync (
    input  logic CLOCKH,
    input  logic rst,
    input  logic din,
    output logic rise
);

    logic s1, s2, s3;

    always_ff @(posedge CLOCKH) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= din;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise = s2 & ~s3;

endmodule

// File: rtl/agc_cdu_link.sv
// rtl/agc_cdu_link.sv - AGC-side CDU link: increment accumulation, CDU counter, mode lines, error-drive pacing
// Ports:
//   CLOCKH in  system clock (only clock)
//   rst    in  synchronous active-high reset
//   link   agc_cdu_link_if.slave: PCDU/MCDU in, cpu_zero/cpu_ca/cpu_eec/ec_wr/ec_val in,
//          cnt_q/AGCZ/AGCCA/AGCEEC/ECP/ECM/ec_busy/cnt_ovf out
// Build option: CDU_LINK_OVF_EN enables the sticky counter-wrap flag cnt_ovf (tied 0 otherwise).
module agc_cdu_link
    import cdu_link_pkg::*;
#(
    parameter int SLOT_DIV = 12,
    parameter int Z_HOLD   = 8,
    parameter int EC_DIV   = 320,
    parameter int PEND_W   = 4
) (
    input  logic          CLOCKH,
    input  logic          rst,
    agc_cdu_link_if.slave link
);

    localparam int SLOT_W = $clog2(SLOT_DIV);
    localparam int Z_W    = $clog2(Z_HOLD + 1);
    localparam int DIV_W  = $clog2(EC_DIV);

    localparam logic signed [PEND_W-1:0] PEND_ONE = PEND_W'(1);
    localparam logic signed [PEND_W-1:0] PEND_MAX = PEND_W'((1 << (PEND_W - 1)) - 1);
    localparam logic signed [PEND_W-1:0] PEND_MIN = -PEND_MAX;

    logic                     p_rise, m_rise;
    logic [SLOT_W-1:0]        slot_cnt;
    logic                     slot_stb;
    logic signed [PEND_W-1:0] pending, pend_svc, pend_nxt;
    logic [CNT_W-1:0]         cnt, cnt_nxt;
    logic                     pend_pos, pend_neg, inc, dec;
    logic                     agcz;
    logic [Z_W-1:0]           z_cnt;
    logic                     agcca, agceec;
    ec_state_t                state, state_nxt;
    logic [EC_W:0]            mag;
    logic                     dir_plus;
    logic [DIV_W-1:0]         ec_div;
    logic                     div_hit;
    logic                     ecp, ecm;

    cdu_pulse_sync u_sync_p (.CLOCKH(CLOCKH), .rst(rst), .din(link.PCDU), .rise(p_rise));
    cdu_pulse_sync u_sync_m (.CLOCKH(CLOCKH), .rst(rst), .din(link.MCDU), .rise(m_rise));

    // Free-running slot divider; one counter-service opportunity per SLOT_DIV cycles.
    always_ff @(posedge CLOCKH) begin
        if (rst)           slot_cnt <= '0;
        else if (slot_stb) slot_cnt <= '0;
        else               slot_cnt <= slot_cnt + SLOT_W'(1);
    end
    assign slot_stb = (slot_cnt == SLOT_W'(SLOT_DIV - 1));

    // Service step first, then this cycle's edge, so a slot-cycle edge nets against the step.
    always_comb begin
        pend_pos = ~pending[PEND_W-1] && (pending != '0);
        pend_neg = pending[PEND_W-1];
        pend_svc = pending;
        cnt_nxt  = cnt;
        if (slot_stb && pend_pos) begin
            cnt_nxt  = cnt + CNT_W'(1);
            pend_svc = pending - PEND_ONE;
        end else if (slot_stb && pend_neg) begin
            cnt_nxt  = cnt - CNT_W'(1);
            pend_svc = pending + PEND_ONE;
        end
        // Simultaneous +/- edges cancel; edges during AGCZ are discarded.
        inc      = p_rise & ~m_rise & ~agcz;
        dec      = m_rise & ~p_rise & ~agcz;
        pend_nxt = pend_svc;
        if (inc && pend_svc != PEND_MAX)      pend_nxt = pend_svc + PEND_ONE;
        else if (dec && pend_svc != PEND_MIN) pend_nxt = pend_svc - PEND_ONE;
    end

    always_ff @(posedge CLOCKH) begin
        if (rst || link.cpu_zero) begin
            cnt     <= '0;
            pending <= '0;
        end else begin
            cnt     <= cnt_nxt;
            pending <= pend_nxt;
        end
    end

    // AGCZ: high for Z_HOLD cycles after the last cpu_zero.
    always_ff @(posedge CLOCKH) begin
        if (rst) begin
            agcz  <= 1'b0;
            z_cnt <= '0;
        end else if (link.cpu_zero) begin
            agcz  <= 1'b1;
            z_cnt <= Z_W'(Z_HOLD - 1);
        end else if (z_cnt != '0) begin
            z_cnt <= z_cnt - Z_W'(1);
        end else begin
            agcz  <= 1'b0;
        end
    end

    always_ff @(posedge CLOCKH) begin
        if (rst) begin
            agcca  <= 1'b0;
            agceec <= 1'b0;
        end else begin
            agcca  <= link.cpu_ca;
            agceec <= link.cpu_eec;
        end
    end

`ifdef CDU_LINK_OVF_EN
    logic ovf;
    logic wrap;
    assign wrap = slot_stb && ((pend_pos && cnt == CNT_MAX) || (pend_neg && cnt == CNT_MIN));
    always_ff @(posedge CLOCKH) begin
        if (rst || link.cpu_zero) ovf <= 1'b0;
        else if (wrap)            ovf <= 1'b1;
    end
    assign link.cnt_ovf = ovf;
`else
    assign link.cnt_ovf = 1'b0;
`endif

    // Error-drive FSM: state register.
    always_ff @(posedge CLOCKH) begin
        if (rst) state <= EC_IDLE;
        else     state <= state_nxt;
    end

    // Error-drive FSM: next state and pulse outputs.
    always_comb begin
        state_nxt = state;
        ecp       = 1'b0;
        ecm       = 1'b0;
        div_hit   = agceec && (ec_div == DIV_W'(EC_DIV - 1));
        case (state)
            EC_IDLE: begin
                if (link.ec_wr && link.ec_val != '0) state_nxt = EC_WAIT;
            end
            EC_WAIT: begin
                if (link.ec_wr && link.ec_val == '0) state_nxt = EC_IDLE;
                else if (div_hit)                    state_nxt = EC_PULSE;
            end
            EC_PULSE: begin
                ecp = dir_plus;
                ecm = ~dir_plus;
                if (link.ec_wr)                       state_nxt = (link.ec_val == '0) ? EC_IDLE : EC_WAIT;
                else if (mag == (EC_W + 1)'(1))       state_nxt = EC_IDLE;
                else                                  state_nxt = EC_WAIT;
            end
            default: state_nxt = EC_IDLE;
        endcase
    end

    // The divider keeps running through the PULSE cycle so pulses land exactly EC_DIV apart.
    always_ff @(posedge CLOCKH) begin
        if (rst) begin
            mag      <= '0;
            dir_plus <= 1'b0;
            ec_div   <= '0;
        end else if (state == EC_IDLE) begin
            if (link.ec_wr) begin
                mag      <= ec_mag(link.ec_val);
                dir_plus <= ~link.ec_val[EC_W-1];
                ec_div   <= '0;
            end
        end else begin
            if (agceec) ec_div <= div_hit ? '0 : ec_div + DIV_W'(1);
            if (link.ec_wr) begin
                mag      <= ec_mag(link.ec_val);
                dir_plus <= ~link.ec_val[EC_W-1];
            end else if (state == EC_PULSE) begin
                mag      <= mag - (EC_W + 1)'(1);
            end
        end
    end

    assign link.cnt_q   = cnt;
    assign link.AGCZ    = agcz;
    assign link.AGCCA   = agcca;
    assign link.AGCEEC  = agceec;
    assign link.ECP     = ecp;
    assign link.ECM     = ecm;
    assign link.ec_busy = (state != EC_IDLE);

endmodule

// File: tb/tb_agc_cdu_link.sv
// tb/tb_agc_cdu_link.sv - directed self-checking bench for agc_cdu_link
module tb_agc_cdu_link;

    logic CLOCKH = 1'b0;
    logic rst    = 1'b1;
    always #5 CLOCKH = ~CLOCKH;

    agc_cdu_link_if lk();
    agc_cdu_link_if fk();

    agc_cdu_link u_dut (.CLOCKH(CLOCKH), .rst(rst), .link(lk.slave));
    agc_cdu_link #(.SLOT_DIV(2)) u_fast (.CLOCKH(CLOCKH), .rst(rst), .link(fk.slave));

    int n_tests = 0;
    int n_fail  = 0;
    int cyc;

    // Edges since reset release; the slot strobe of u_dut fires on edges where cyc % 12 == 0.
    always @(posedge CLOCKH) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge CLOCKH);
    endtask

    task automatic wait_phase(input int r);
        int g;
        g = 0;
        do begin
            @(negedge CLOCKH);
            g++;
        end while ((cyc % 12) != r && g < 24);
        if ((cyc % 12) != r) check("wait_phase_timeout", 32'(cyc % 12), 32'(r));
    endtask

    task automatic wait_until(input int c);
        int g;
        g = 0;
        while (cyc < c && g < 2000) begin
            @(negedge CLOCKH);
            g++;
        end
        if (cyc < c) check("wait_until_timeout", 32'(cyc), 32'(c));
    endtask

    int c0, agcz_n, ecm_n, ecp_n, both_n, busy_fall;
    int ecm_t[3];

    initial begin
        lk.PCDU = 0; lk.MCDU = 0; lk.cpu_zero = 0; lk.cpu_ca = 0; lk.cpu_eec = 0;
        lk.ec_wr = 0; lk.ec_val = 8'h00;
        fk.PCDU = 0; fk.MCDU = 0; fk.cpu_zero = 0; fk.cpu_ca = 0; fk.cpu_eec = 0;
        fk.ec_wr = 0; fk.ec_val = 8'h00;

        // Reset state
        tick(3);
        check("rst_cnt", 32'(lk.cnt_q), 0);
        check("rst_outs", {25'd0, lk.AGCZ, lk.AGCCA, lk.AGCEEC, lk.ECP, lk.ECM, lk.ec_busy, lk.cnt_ovf}, 0);
        rst = 0;

        // Mode lines: one-cycle registered copies
        lk.cpu_ca = 1;
        tick(1);
        check("agcca_set", 32'(lk.AGCCA), 1);
        lk.cpu_ca = 0;
        tick(1);
        check("agcca_clr", 32'(lk.AGCCA), 0);

        // Five single PCDU pulses; each lands on the next slot edge
        for (int i = 0; i < 5; i++) begin
            wait_phase(0);
            lk.PCDU = 1;
            tick(1);
            lk.PCDU = 0;
            wait_phase(11);
            check("inc_before_slot", 32'(lk.cnt_q), 32'(i));
            wait_phase(0);
            check("inc_on_slot", 32'(lk.cnt_q), 32'(i + 1));
            tick(27);
        end

        // Burst of 10 edges; adds land on odd offsets, one slot service inside the burst,
        // then pending saturates at 7: total +8.
        wait_phase(10);
        c0 = cyc;
        for (int i = 0; i < 10; i++) begin
            lk.PCDU = 1;
            tick(1);
            lk.PCDU = 0;
            tick(1);
        end
        check("burst_end", 32'(lk.cnt_q), 6);
        wait_until(c0 + 90);
        check("burst_drain6", 32'(lk.cnt_q), 12);
        wait_until(c0 + 100);
        check("burst_sat", 32'(lk.cnt_q), 13);
        tick(48);
        check("burst_settled", 32'(lk.cnt_q), 13);

        // Simultaneous PCDU/MCDU cancel; lone MCDU decrements
        lk.PCDU = 1; lk.MCDU = 1;
        tick(1);
        lk.PCDU = 0; lk.MCDU = 0;
        tick(40);
        check("both_edges", 32'(lk.cnt_q), 13);
        lk.MCDU = 1;
        tick(1);
        lk.MCDU = 0;
        tick(30);
        check("mcdu_dec", 32'(lk.cnt_q), 12);

        // Bring counter to 100, then zero with a PCDU edge during AGCZ
        for (int i = 0; i < 88; i++) begin
            lk.PCDU = 1;
            tick(1);
            lk.PCDU = 0;
            tick(11);
        end
        tick(30);
        check("cnt_100", 32'(lk.cnt_q), 100);
        lk.cpu_zero = 1;
        tick(1);
        lk.cpu_zero = 0;
        check("zero_cnt", 32'(lk.cnt_q), 0);
        agcz_n = int'(lk.AGCZ);
        lk.PCDU = 1;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            lk.PCDU = 0;
            agcz_n += int'(lk.AGCZ);
        end
        check("agcz_len", 32'(agcz_n), 8);
        tick(30);
        check("zero_edge_drop", 32'(lk.cnt_q), 0);

        // Error drive -3: ECM at 320, pause over cpu_eec low, resume
        lk.cpu_eec = 1;
        tick(2);
        lk.ec_wr = 1; lk.ec_val = 8'hFD;
        tick(1);
        lk.ec_wr = 0;
        check("ec_busy_set", 32'(lk.ec_busy), 1);
        ecm_n = 0; ecp_n = 0; both_n = 0; busy_fall = -1;
        for (int i = 0; i < 3; i++) ecm_t[i] = -1;
        for (int t = 1; t <= 1500; t++) begin
            tick(1);
            if (lk.ECM) begin
                if (ecm_n < 3) ecm_t[ecm_n] = t;
                ecm_n++;
            end
            if (lk.ECP) ecp_n++;
            if (lk.ECP && lk.ECM) both_n++;
            if (!lk.ec_busy && busy_fall < 0) busy_fall = t;
            if (t == 320) lk.cpu_eec = 0;
            if (t == 820) lk.cpu_eec = 1;
        end
        check("ecm_1st", 32'(ecm_t[0]), 320);
        check("ecm_2nd_after_pause", 32'(ecm_t[1]), 1140);
        check("ecm_3rd", 32'(ecm_t[2]), 1460);
        check("ecm_count", 32'(ecm_n), 3);
        check("ecp_count", 32'(ecp_n), 0);
        check("ecp_ecm_both", 32'(both_n), 0);
        check("busy_fall", 32'(busy_fall), 1461);

        // Rewrite with 0 cancels; -128 is a valid nonzero load
        lk.ec_wr = 1; lk.ec_val = 8'h05;
        tick(1);
        lk.ec_wr = 0;
        tick(5);
        lk.ec_wr = 1; lk.ec_val = 8'h00;
        tick(1);
        lk.ec_wr = 0;
        check("ec_cancel", 32'(lk.ec_busy), 0);
        lk.ec_wr = 1; lk.ec_val = 8'h80;
        tick(1);
        lk.ec_wr = 0;
        check("ec_m128_busy", 32'(lk.ec_busy), 1);

        // Wrap on the fast-slot instance: 16383 increments, then one more
        for (int i = 0; i < 16383; i++) begin
            fk.PCDU = 1;
            tick(1);
            fk.PCDU = 0;
            tick(1);
        end
        tick(20);
        check("fast_max", 32'(fk.cnt_q), 16383);
        check("fast_ovf_pre", 32'(fk.cnt_ovf), 0);
        fk.PCDU = 1;
        tick(1);
        fk.PCDU = 0;
        tick(20);
        check("fast_wrap", 32'(fk.cnt_q), 32'h4000);
`ifdef CDU_LINK_OVF_EN
        check("fast_ovf_set", 32'(fk.cnt_ovf), 1);
`else
        check("fast_ovf_off", 32'(fk.cnt_ovf), 0);
`endif
        fk.cpu_zero = 1;
        tick(1);
        fk.cpu_zero = 0;
        check("fast_zero_cnt", 32'(fk.cnt_q), 0);
        check("fast_zero_ovf", 32'(fk.cnt_ovf), 0);

        // Reset mid-operation
        for (int i = 0; i < 3; i++) begin
            lk.PCDU = 1;
            tick(1);
            lk.PCDU = 0;
            tick(13);
        end
        tick(20);
        check("pre_rst_cnt", 32'(lk.cnt_q), 3);
        rst = 1;
        tick(1);
        check("mid_rst_cnt", 32'(lk.cnt_q), 0);
        check("mid_rst_busy", {29'd0, lk.ec_busy, lk.AGCEEC, lk.ECM}, 0);
        rst = 0;
        tick(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
